// File: rtl/npu_pkg.sv
// Shared definitions for the NPU activation feeder: FSM states, flush length
// and lane slicing helpers.
package npu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam int unsigned NPU_N     = 3;
  localparam int unsigned FLUSH_CYC = 2 * NPU_N - 1;

  function automatic int unsigned flush_cycles(input int unsigned n);
    return 2 * n - 1;
  endfunction

  // Low bit of lane k within a packed row of dw-bit lanes.
  function automatic int unsigned lane_lo(input int unsigned k, input int unsigned dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/npu_skew_line.sv
// Per-lane delay line of DEPTH stages; shifts only when en is high and is
// synchronously cleared by clr.
module npu_skew_line #(
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout
);

  logic [DEPTH-1:0][DWIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (en) begin
      sr_d[0] = din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr_d[i] = sr_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/npu_act_feeder.sv
// Activation feeder: accepts rows over valid/ready, skews lane k by k
// advances, then flushes 2N-1 zero advances so the array drains.
module npu_act_feeder
  import npu_pkg::*;
#(
  parameter int unsigned N      = 3,
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned CWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CWIDTH-1:0]   num_rows,
  input  logic                s_valid,
  input  logic [N*DWIDTH-1:0] s_data,
  output logic                s_ready,
  output logic [N*DWIDTH-1:0] a_data,
  output logic                a_en,
  output logic                busy,
  output logic                done
);

  localparam int unsigned FLUSH_N = flush_cycles(N);
  localparam int unsigned FW      = $clog2(FLUSH_N + 1);

  state_e              state_q, state_d;
  logic [CWIDTH-1:0]   cnt_q, cnt_d, num_q, num_d, cnt_inc;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic [N*DWIDTH-1:0] a_data_q, a_data_d, adv_data;
  logic                a_en_q, a_en_d, done_q, done_d;
  logic                job_start, adv;
  logic [DWIDTH-1:0]   dl_out [1:N-1];

  assign job_start = (state_q == ST_IDLE) && start;
  assign adv       = ((state_q == ST_LOAD) && s_valid) || (state_q == ST_FLUSH);
  assign adv_data  = (state_q == ST_LOAD) ? s_data : '0;
  assign cnt_inc   = cnt_q + CWIDTH'(1);

  for (genvar k = 1; k < N; k++) begin : g_skew
    npu_skew_line #(
      .DEPTH  (k),
      .DWIDTH (DWIDTH)
    ) u_line (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (job_start),
      .en    (adv),
      .din   (adv_data[lane_lo(k, DWIDTH) +: DWIDTH]),
      .dout  (dl_out[k])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    fcnt_d   = fcnt_q;
    done_d   = 1'b0;
    a_en_d   = adv;
    a_data_d = a_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d    = num_rows;
          cnt_d    = '0;
          fcnt_d   = '0;
          a_data_d = '0;
          state_d  = (num_rows == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (s_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == num_q) begin
            state_d = ST_FLUSH;
            fcnt_d  = '0;
          end
        end
      end
      ST_FLUSH: begin
        fcnt_d = fcnt_q + FW'(1);
        if (fcnt_q == FW'(FLUSH_N - 1)) begin
          state_d = ST_DONE;
        end
      end
      // DONE spans two cycles: the one showing the last advance, then the
      // done pulse, so busy stays high through the pulse.
      ST_DONE: begin
        if (done_q) begin
          state_d = ST_IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (adv) begin
      a_data_d[DWIDTH-1:0] = adv_data[DWIDTH-1:0];
      for (int unsigned k = 1; k < N; k++) begin
        a_data_d[lane_lo(k, DWIDTH) +: DWIDTH] = dl_out[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      num_q    <= '0;
      fcnt_q   <= '0;
      a_data_q <= '0;
      a_en_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      fcnt_q   <= fcnt_d;
      a_data_q <= a_data_d;
      a_en_q   <= a_en_d;
      done_q   <= done_d;
    end
  end

  assign s_ready = (state_q == ST_LOAD);
  assign busy    = (state_q != ST_IDLE);
  assign a_data  = a_data_q;
  assign a_en    = a_en_q;
  assign done    = done_q;

endmodule

// File: tb/tb_npu_act_feeder.sv
// Self-checking bench for npu_act_feeder with a row-level skew model.
module tb_npu_act_feeder;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;
  localparam int          FLUSH = 2 * N - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [CW-1:0]   num_rows = '0;
  logic            s_valid = 1'b0;
  logic [N*DW-1:0] s_data = '0;
  logic            s_ready;
  logic [N*DW-1:0] a_data;
  logic            a_en, busy, done;

  int checks = 0;
  int errors = 0;

  logic [N*DW-1:0] rows_q [$];

  npu_act_feeder #(
    .N      (N),
    .DWIDTH (DW),
    .CWIDTH (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .num_rows (num_rows),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .a_data   (a_data),
    .a_en     (a_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit exceeded");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance t of a job: lane k holds byte k of row t-k, or zero outside the job.
  function automatic logic [N*DW-1:0] exp_adata(input int t);
    logic [N*DW-1:0] res;
    logic [N*DW-1:0] r;
    res = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (t - k >= 0 && t - k < rows_q.size()) begin
        r = rows_q[t-k];
        res[k*DW +: DW] = r[k*DW +: DW];
      end
    end
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'(0));
    chk({tag, "_a_data"},  32'(a_data),  32'(0));
    chk({tag, "_a_en"},    32'(a_en),    32'(0));
    chk({tag, "_busy"},    32'(busy),    32'(0));
    chk({tag, "_done"},    32'(done),    32'(0));
  endtask

  // stall_mode: 0 none, 1 random, 2 two-cycle gap before row 1.
  // abort_at > 0: assert reset after that many flush advances.
  task automatic run_job(input int stall_mode, input bit noise, input int abort_at);
    int  n, sent, flush_left, fl_done, t, gap, cyc;
    bit  will_adv, acc, v;
    n = rows_q.size();
    sent = 0; flush_left = 0; fl_done = 0; t = 0; gap = 0; cyc = 0;

    start = 1'b1; num_rows = CW'(n); s_valid = 1'b0; s_data = N*DW'($urandom);
    step();
    start = 1'b0;
    chk("start_busy",    32'(busy),    32'(1));
    chk("start_s_ready", 32'(s_ready), 32'(n > 0));
    chk("start_a_en",    32'(a_en),    32'(0));
    chk("start_done",    32'(done),    32'(0));
    chk("start_a_data",  32'(a_data),  32'(0));

    while (sent < n || flush_left > 0) begin
      cyc++;
      if (cyc > 1000) begin
        checks++; errors++;
        $error("FAIL job_budget observed=%0d expected<=1000", cyc);
        break;
      end
      acc = 1'b0; will_adv = 1'b0; s_valid = 1'b0; s_data = N*DW'($urandom); start = 1'b0;
      if (sent < n) begin
        chk("load_s_ready", 32'(s_ready), 32'(1));
        case (stall_mode)
          1:       v = ($urandom_range(0, 2) != 0);
          2:       begin v = !(sent == 1 && gap < 2); if (!v) gap++; end
          default: v = 1'b1;
        endcase
        s_valid = v;
        if (v) s_data = rows_q[sent];
        acc = v; will_adv = v;
      end else begin
        chk("flush_s_ready", 32'(s_ready), 32'(0));
        will_adv = 1'b1;
      end
      if (noise && $urandom_range(0, 3) == 0) begin
        start = 1'b1; num_rows = CW'($urandom);
      end
      step();
      chk("a_en", 32'(a_en), 32'(will_adv));
      chk("busy", 32'(busy), 32'(1));
      chk("done_early", 32'(done), 32'(0));
      if (will_adv) begin
        chk("a_data", 32'(a_data), 32'(exp_adata(t)));
        t++;
      end else begin
        chk("a_data_hold", 32'(a_data), 32'((t == 0) ? '0 : exp_adata(t - 1)));
      end
      if (acc) begin
        sent++;
        if (sent == n) flush_left = FLUSH;
      end else if (will_adv) begin
        flush_left--;
        fl_done++;
        if (abort_at > 0 && fl_done == abort_at) begin
          start = 1'b0; s_valid = 1'b0;
          rst_n = 1'b0;
          #1;
          check_all_zero("abort_now");
          step();
          check_all_zero("abort_hold");
          rst_n = 1'b1;
          step();
          check_all_zero("abort_release");
          return;
        end
      end
    end

    start = noise; num_rows = CW'($urandom); s_valid = 1'b0;
    step();
    start = 1'b0;
    chk("done_pulse",   32'(done),    32'(1));
    chk("done_busy",    32'(busy),    32'(1));
    chk("done_a_en",    32'(a_en),    32'(0));
    chk("done_s_ready", 32'(s_ready), 32'(0));
    chk("done_a_data",  32'(a_data),  32'((t == 0) ? '0 : exp_adata(t - 1)));
    start = noise; num_rows = CW'($urandom | 1);
    step();
    start = 1'b0;
    chk("after_done", 32'(done), 32'(0));
    chk("after_busy", 32'(busy), 32'(0));
    chk("after_a_en", 32'(a_en), 32'(0));
  endtask

  task automatic rand_rows(input int n);
    rows_q.delete();
    for (int i = 0; i < n; i++) rows_q.push_back(N*DW'($urandom));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); s_valid = 1'($urandom);
      num_rows = CW'($urandom); s_data = N*DW'($urandom);
      step();
      check_all_zero("reset");
    end
    start = 1'b0; s_valid = 1'b0;
    rst_n = 1'b1;
    step();
    check_all_zero("post_reset");

    rows_q = '{24'h030201, 24'h060504, 24'h090807};
    run_job(0, 1'b0, 0);

    run_job(2, 1'b0, 0);

    rows_q.delete();
    run_job(0, 1'b0, 0);

    rand_rows(4);
    run_job(1, 1'b1, 0);

    for (int j = 0; j < 5; j++) begin
      rand_rows($urandom_range(1, 6));
      run_job(1, 1'($urandom), 0);
    end

    rows_q = '{24'hA3B2C1, 24'hD6E5F4, 24'h192837};
    run_job(0, 1'b0, 2);

    rand_rows(2);
    run_job(0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
